// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// No logic of its own: state encoding, word width, address decode.
// The decode helper is purely combinational.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic [29:0] idx;
    logic        err;
  } addr_dec_t;

  // Word index wraps modulo depth; err flags misalignment or an address past the array.
  function automatic addr_dec_t decode_addr(input logic [31:0] addr, input logic [31:0] depth);
    addr_dec_t d;
    d.idx = addr[31:2] & 30'(depth - 32'd1);
    d.err = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    return d;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's load/store path and the responder.
// No latency: wires only.
// Valid/ready on both channels; master drives requests and rsp_ready.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage, one write port and one read port.
// Write lands on the clock edge; read is combinational from ridx.
// No flow control; contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     ridx,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Synchronous word write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: one outstanding word load/store at a time.
// Response valid exactly LATENCY edges after request acceptance.
// req_ready only in IDLE; response held stable until rsp_ready, one bubble after handshake.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_e       state;
  logic [3:0]        cnt;
  logic              cap_write;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  addr_dec_t         dec;
  logic [AW-1:0]     widx;
  logic [WORD_W-1:0] rd_data;
  logic              access;
  logic              mem_we;
  logic              unused_idx_hi;

  // Decode always works on the captured address so late req_* changes cannot leak in.
  assign dec           = decode_addr(cap_addr, 32'(DEPTH));
  assign widx          = dec.idx[AW-1:0];
  assign unused_idx_hi = ^dec.idx[29:AW];

  assign access = (state == S_WAIT) && (cnt == 4'd0);
  assign mem_we = access && cap_write && !dec.err;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .widx  (widx),
    .wdata (cap_wdata),
    .ridx  (widx),
    .rdata (rd_data)
  );

  // Request capture, latency countdown, access and response hand-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      cap_write   <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            cap_write <= bus.req_write;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cnt       <= 4'(LATENCY - 1);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_err_q   <= dec.err;
            rsp_rdata_q <= (!cap_write && !dec.err) ? rd_data : '0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 4, 1) against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  int          sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  int          n_tests;
  int          n_fail;
  int          lat_of [3];
  logic [31:0] mdl_mem [3][DEPTH];
  bit          mdl_known [3][DEPTH];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  data_mem_responder_if bus2 ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus0));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_lat4 (.clk(clk), .rst(rst), .bus(bus1));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.req_valid = req_valid && (sel == 0);
  assign bus1.req_valid = req_valid && (sel == 1);
  assign bus2.req_valid = req_valid && (sel == 2);
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.rsp_ready = rsp_ready;
  assign bus2.rsp_ready = rsp_ready;

  always_comb begin
    o_req_ready = bus0.req_ready;
    o_rsp_valid = bus0.rsp_valid;
    o_rsp_rdata = bus0.rsp_rdata;
    o_rsp_err   = bus0.rsp_err;
    if (sel == 1) begin
      o_req_ready = bus1.req_ready;
      o_rsp_valid = bus1.rsp_valid;
      o_rsp_rdata = bus1.rsp_rdata;
      o_rsp_err   = bus1.rsp_err;
    end else if (sel == 2) begin
      o_req_ready = bus2.req_ready;
      o_rsp_valid = bus2.rsp_valid;
      o_rsp_rdata = bus2.rsp_rdata;
      o_rsp_err   = bus2.rsp_err;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_is_err(input logic [31:0] addr);
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
  endfunction

  // One full transaction with optional response backpressure of 'hold' cycles.
  task automatic do_txn(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
    int          n;
    bit          ok;
    bit          exp_err;
    int          idx;
    logic [31:0] exp_rd;
    logic [31:0] sv_rd;
    logic        sv_err;
    exp_err = addr_is_err(addr);
    idx     = exp_err ? 0 : int'(addr / 4);
    exp_rd  = (!wr && !exp_err) ? mdl_mem[d][idx] : 32'h0;

    @(negedge clk);
    sel       = d;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;

    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (o_rsp_valid) begin
        ok = 1'b1;
        n  = i;
      end
    end
    if (!ok) begin
      chk("rsp_valid_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(n), 32'(lat_of[d]));
    chk("rsp_err", 32'(o_rsp_err), 32'(exp_err));
    chk("rsp_rdata", o_rsp_rdata, exp_rd);

    if (hold > 0) begin
      sv_rd  = o_rsp_rdata;
      sv_err = o_rsp_err;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        chk("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("bp_req_ready", 32'(o_req_ready), 32'd0);
        chk("bp_rdata", o_rsp_rdata, sv_rd);
        chk("bp_err", 32'(o_rsp_err), 32'(sv_err));
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("post_hs_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(o_req_ready), 32'd1);

    if (wr && !exp_err) begin
      mdl_mem[d][idx]   = wd;
      mdl_known[d][idx] = 1'b1;
    end
  endtask

  initial begin
    int          nrsp;
    int          d;
    int          w;
    int          kind;
    bit          wr;
    logic [31:0] addr;

    n_tests   = 0;
    n_fail    = 0;
    lat_of    = '{2, 4, 1};
    sel       = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        mdl_mem[k][j]   = 32'h0;
        mdl_known[k][j] = 1'b0;
      end
    end

    #3;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("reset_req_ready", 32'(o_req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("reset_rdata", o_rsp_rdata, 32'h0);
      chk("reset_err", 32'(o_rsp_err), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed, LATENCY=2.
    do_txn(0, 1'b1, 32'h0000_0000, 32'h1234_5678, 0);
    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 0);
    do_txn(0, 1'b0, 32'h0000_0013, 32'h0, 0);
    do_txn(0, 1'b0, 32'h0000_1000, 32'h0, 0);
    do_txn(0, 1'b1, 32'h0000_1000, 32'hFFFF_0000, 0);
    do_txn(0, 1'b1, 32'h0000_0012, 32'hFFFF_1111, 0);
    do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 5);
    do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 0);

    // Reset in the middle of WAIT, LATENCY=4: pending store must be dropped.
    do_txn(1, 1'b1, 32'h0000_0020, 32'h0, 0);
    do_txn(1, 1'b1, 32'h0000_0024, 32'hCAFE_0001, 0);
    do_txn(1, 1'b0, 32'h0000_0024, 32'h0, 0);
    @(negedge clk);
    sel       = 1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'h0000_0055;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_wait_req_ready", 32'(o_req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_req_ready", 32'(o_req_ready), 32'd1);
    chk("arst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("arst_rdata", o_rsp_rdata, 32'h0);
    chk("arst_err", 32'(o_rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_txn(1, 1'b0, 32'h0000_0020, 32'h0, 0);

    // LATENCY=1 back-to-back loads with rsp_ready held high.
    do_txn(2, 1'b1, 32'h0000_0040, 32'h0A0A_0001, 0);
    do_txn(2, 1'b1, 32'h0000_0044, 32'h0B0B_0002, 0);
    do_txn(2, 1'b1, 32'h0000_0048, 32'h0C0C_0003, 0);
    @(negedge clk);
    sel       = 2;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0040;
    @(posedge clk);
    #1;
    nrsp = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("b2b_rsp_valid", 32'(o_rsp_valid), 32'(i % 3 == 1));
      chk("b2b_req_ready", 32'(o_req_ready), 32'(i % 3 == 2));
      if (o_rsp_valid) begin
        chk("b2b_rdata", o_rsp_rdata, mdl_mem[2][16 + nrsp]);
        nrsp++;
        if (nrsp < 3) req_addr = 32'h40 + 32'(4 * nrsp);
      end
      if (i == 8) req_valid = 1'b0;
    end
    chk("b2b_count", 32'(nrsp), 32'd3);
    @(posedge clk);
    #1;

    // Randomized traffic across all three latencies.
    for (int t = 0; t < 150; t++) begin
      d    = int'($urandom_range(0, 2));
      w    = int'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 9));
      wr   = 1'($urandom);
      if (kind <= 6)      addr = 32'(w * 4);
      else if (kind == 7) addr = 32'(w * 4) + 32'($urandom_range(1, 3));
      else if (kind == 8) addr = 32'h1000 + 32'($urandom_range(0, 1000) * 4);
      else                addr = $urandom;
      if (!wr && !addr_is_err(addr) && !mdl_known[d][addr / 4]) wr = 1'b1;
      do_txn(d, wr, addr, $urandom, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
